// File: rtl/onfi_pkg.sv
// Shared types and constants for the ONFI dummy-NAND command front end:
// operation codes, FSM states, command bytes and status-register bit positions.
package onfi_pkg;

  typedef enum logic [2:0] {
    OP_NONE   = 3'd0,
    OP_READ   = 3'd1,
    OP_PROG   = 3'd2,
    OP_ERASE  = 3'd3,
    OP_RESET  = 3'd4,
    OP_READID = 3'd5,
    OP_STATUS = 3'd6
  } op_code_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CONFIRM,
    S_DATA_IN,
    S_BUSY
  } state_t;

  // Which multi-cycle command sequence is in flight.
  typedef enum logic [1:0] {
    SEQ_READ,
    SEQ_PROG,
    SEQ_ERASE,
    SEQ_READID
  } seq_t;

  localparam logic [7:0] CMD_READ       = 8'h00;
  localparam logic [7:0] CMD_READ_CONF  = 8'h30;
  localparam logic [7:0] CMD_PROG       = 8'h80;
  localparam logic [7:0] CMD_PROG_CONF  = 8'h10;
  localparam logic [7:0] CMD_ERASE      = 8'h60;
  localparam logic [7:0] CMD_ERASE_CONF = 8'hD0;
  localparam logic [7:0] CMD_STATUS     = 8'h70;
  localparam logic [7:0] CMD_READ_ID    = 8'h90;
  localparam logic [7:0] CMD_RESET      = 8'hFF;

  localparam int SR_FAIL = 0;
  localparam int SR_ARDY = 5;
  localparam int SR_RDY  = 6;
  localparam int SR_WP_N = 7;

endpackage

// File: rtl/onfi_pin_sync.sv
// Two-flop synchroniser for the asynchronous SDR pins plus WE_x_n rising-edge
// detection; we_evt fires for one clk when a latch edge is seen with CE low.
module onfi_pin_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce_n,
  input  logic       cle,
  input  logic       ale,
  input  logic       we_n,
  input  logic       wp_n,
  input  logic [7:0] io,
  output logic       ce_n_s,
  output logic       cle_s,
  output logic       ale_s,
  output logic       wp_n_s,
  output logic [7:0] io_s,
  output logic       we_evt
);

  // Packed as {ce_n, we_n, wp_n, cle, ale, io}; the active-low pins idle high.
  localparam logic [12:0] PIN_IDLE = 13'h1C00;

  logic [12:0] meta, sync;
  logic        we_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta    <= PIN_IDLE;
      sync    <= PIN_IDLE;
      we_prev <= 1'b1;
    end else begin
      meta    <= {ce_n, we_n, wp_n, cle, ale, io};
      sync    <= meta;
      we_prev <= sync[11];
    end
  end

  assign ce_n_s = sync[12];
  assign wp_n_s = sync[10];
  assign cle_s  = sync[9];
  assign ale_s  = sync[8];
  assign io_s   = sync[7:0];
  assign we_evt = sync[11] & ~we_prev & ~sync[12];

endmodule

// File: rtl/onfi_cmd_decoder.sv
// ONFI target front end: decodes synchronised command/address/data cycles into
// one-cycle op/data strobes, models busy timing and the status byte.
// Optional build macro ONFI_READ_ID_EN enables the 0x90 read-ID sequence.
module onfi_cmd_decoder
  import onfi_pkg::*;
#(
  parameter int COL_CYCLES    = 2,
  parameter int ROW_CYCLES    = 3,
  parameter int PAGE_BYTES    = 4096,
  parameter int T_R_CYCLES    = 250,
  parameter int T_PROG_CYCLES = 1000,
  parameter int T_BERS_CYCLES = 3000,
  parameter int T_RST_CYCLES  = 50
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          CE_x_n,
  input  logic                          CLE_x,
  input  logic                          ALE_x,
  input  logic                          WE_x_n,
  input  logic                          WP_x_n,
  input  logic [7:0]                    IO_bus,
  output logic                          RB_x_n,
  output logic                          op_valid,
  output logic [2:0]                    op_code,
  output logic [15:0]                   col_addr,
  output logic [23:0]                   row_addr,
  output logic                          data_valid,
  output logic [7:0]                    data_byte,
  output logic [$clog2(PAGE_BYTES)-1:0] data_idx,
  output logic                          data_ovf,
  output logic [7:0]                    status_reg
);

  localparam int IDX_W = $clog2(PAGE_BYTES);

  logic       ce_n_s, cle_s, ale_s, wp_n_s, we_evt;
  logic [7:0] io_s;

  onfi_pin_sync u_sync (
    .clk(clk), .rst(rst), .ce_n(CE_x_n), .cle(CLE_x), .ale(ALE_x), .we_n(WE_x_n),
    .wp_n(WP_x_n), .io(IO_bus), .ce_n_s(ce_n_s), .cle_s(cle_s), .ale_s(ale_s),
    .wp_n_s(wp_n_s), .io_s(io_s), .we_evt(we_evt)
  );

  state_t     st, nxt;
  seq_t       seq, seq_nxt;
  op_code_t   op_req, op_code_q;
  logic [2:0] addr_cnt, addr_total, row_idx;
  logic [15:0] timer, timer_val;
  logic [IDX_W:0] data_cnt;
  logic load_timer, seq_start, addr_wr, data_wr, set_fail, clr_fail, idle_cmd, fail;

  wire cmd_evt    = we_evt & cle_s & ~ale_s;
  wire addr_evt   = we_evt & ale_s & ~cle_s;
  wire data_evt   = we_evt & ~cle_s & ~ale_s;
  wire status_cmd = cmd_evt && (io_s == CMD_STATUS);
  wire reset_cmd  = cmd_evt && (io_s == CMD_RESET);
  wire seq_cmd    = cmd_evt && !status_cmd && !reset_cmd;

  always_comb begin
    case (seq)
      SEQ_ERASE:  addr_total = 3'(ROW_CYCLES);
      SEQ_READID: addr_total = 3'd1;
      default:    addr_total = 3'(COL_CYCLES + ROW_CYCLES);
    endcase
  end

  assign row_idx = (seq == SEQ_ERASE) ? addr_cnt : addr_cnt - 3'(COL_CYCLES);

  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= S_IDLE;
      seq <= SEQ_READ;
    end else begin
      st  <= nxt;
      seq <= seq_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first so that no branch leaves a signal unassigned and infers a latch.
    nxt = st;  seq_nxt = seq;  op_req = OP_NONE;  load_timer = 1'b0;  timer_val = '0;
    seq_start = 1'b0;  addr_wr = 1'b0;  data_wr = 1'b0;
    set_fail = 1'b0;  clr_fail = 1'b0;  idle_cmd = 1'b0;
    if (status_cmd) op_req = OP_STATUS;
    if (reset_cmd) begin
      op_req = OP_RESET;  nxt = S_BUSY;  clr_fail = 1'b1;
      load_timer = 1'b1;  timer_val = 16'(T_RST_CYCLES - 1);
    end else begin
      unique case (st)
        S_IDLE: idle_cmd = seq_cmd;
        S_ADDR: begin
          if (ce_n_s) nxt = S_IDLE;
          else if (seq_cmd) begin
            nxt = S_IDLE;  idle_cmd = 1'b1;
          end else if (addr_evt && addr_cnt < addr_total) begin
            addr_wr = 1'b1;
            if (addr_cnt == addr_total - 3'd1) begin
              case (seq)
                SEQ_PROG:   nxt = S_DATA_IN;
                SEQ_READID: begin nxt = S_IDLE;  op_req = OP_READID; end
                default:    nxt = S_CONFIRM;
              endcase
            end
          end
        end
        S_CONFIRM: begin
          if (ce_n_s) nxt = S_IDLE;
          else if (seq_cmd) begin
            if (seq == SEQ_READ && io_s == CMD_READ_CONF) begin
              op_req = OP_READ;  nxt = S_BUSY;
              load_timer = 1'b1;  timer_val = 16'(T_R_CYCLES - 1);
            end else if (seq == SEQ_ERASE && io_s == CMD_ERASE_CONF) begin
              if (wp_n_s) begin
                op_req = OP_ERASE;  nxt = S_BUSY;
                load_timer = 1'b1;  timer_val = 16'(T_BERS_CYCLES - 1);
              end else begin
                set_fail = 1'b1;  nxt = S_IDLE;
              end
            end else begin
              nxt = S_IDLE;  idle_cmd = 1'b1;
            end
          end
        end
        S_DATA_IN: begin
          if (ce_n_s) nxt = S_IDLE;
          else if (seq_cmd) begin
            if (io_s == CMD_PROG_CONF) begin
              if (wp_n_s) begin
                op_req = OP_PROG;  nxt = S_BUSY;
                load_timer = 1'b1;  timer_val = 16'(T_PROG_CYCLES - 1);
              end else begin
                set_fail = 1'b1;  nxt = S_IDLE;
              end
            end else begin
              nxt = S_IDLE;  idle_cmd = 1'b1;
            end
          end else if (data_evt) data_wr = 1'b1;
        end
        S_BUSY: if (timer == '0) nxt = S_IDLE;
        default: nxt = S_IDLE;
      endcase
    end
    // An aborting command is re-decoded here as if it arrived in IDLE.
    if (idle_cmd) begin
      case (io_s)
        CMD_READ:  begin nxt = S_ADDR; seq_nxt = SEQ_READ;  seq_start = 1'b1; clr_fail = 1'b1; end
        CMD_PROG:  begin nxt = S_ADDR; seq_nxt = SEQ_PROG;  seq_start = 1'b1; clr_fail = 1'b1; end
        CMD_ERASE: begin nxt = S_ADDR; seq_nxt = SEQ_ERASE; seq_start = 1'b1; clr_fail = 1'b1; end
`ifdef ONFI_READ_ID_EN
        CMD_READ_ID: begin nxt = S_ADDR; seq_nxt = SEQ_READID; seq_start = 1'b1; end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_valid <= 1'b0;  op_code_q <= OP_NONE;  col_addr <= '0;  row_addr <= '0;
      data_valid <= 1'b0;  data_byte <= '0;  data_idx <= '0;  data_ovf <= 1'b0;
      data_cnt <= '0;  addr_cnt <= '0;  timer <= '0;  fail <= 1'b0;
    end else begin
      op_valid   <= (op_req != OP_NONE);
      data_valid <= 1'b0;
      if (op_req != OP_NONE) op_code_q <= op_req;
      if (load_timer) timer <= timer_val;
      else if (st == S_BUSY && timer != '0) timer <= timer - 16'd1;
      if (set_fail) fail <= 1'b1;
      else if (clr_fail) fail <= 1'b0;
      if (seq_start) begin
        addr_cnt <= '0;  col_addr <= '0;  row_addr <= '0;
        if (seq_nxt == SEQ_PROG) begin
          data_cnt <= '0;  data_idx <= '0;  data_ovf <= 1'b0;
        end
      end
      if (addr_wr) begin
        for (int i = 0; i < 2; i++)
          if (i < COL_CYCLES && seq != SEQ_ERASE && int'(addr_cnt) == i) col_addr[8*i +: 8] <= io_s;
        for (int i = 0; i < 3; i++)
          if (i < ROW_CYCLES && int'(row_idx) == i) row_addr[8*i +: 8] <= io_s;
        addr_cnt <= addr_cnt + 3'd1;
      end
      if (data_wr) begin
        if (data_cnt < (IDX_W+1)'(PAGE_BYTES)) begin
          data_valid <= 1'b1;
          data_byte  <= io_s;
          data_idx   <= data_cnt[IDX_W-1:0];
          data_cnt   <= data_cnt + 1'b1;
        end else data_ovf <= 1'b1;
      end
    end
  end

  assign op_code = op_code_q;

  always_comb begin
    RB_x_n     = (st != S_BUSY);
    status_reg = '0;
    status_reg[SR_WP_N] = wp_n_s;
    status_reg[SR_RDY]  = (st != S_BUSY);
    status_reg[SR_ARDY] = (st != S_BUSY);
    status_reg[SR_FAIL] = fail;
  end

endmodule
